// File: rtl/fetch_stage_pkg.sv
// Shared MIPS definitions for the fetch stage and the decode controller:
// reset/NOP encodings, primary opcodes and the IF/ID register layout.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;  // sll $0,$0,0

  // Primary opcodes (instr[31:26]) shared with the decode controller
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [31:0] pc_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction memory port and IF/ID outputs.
// master = the fetch stage itself, slave = the surrounding pipeline/memory.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic        Stall;
  logic        PCSrc;
  logic [31:0] BranchTarget;
  logic [31:0] IMemAddr;
  logic [31:0] IMemData;
  logic [31:0] PC;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;

  modport master (
    input  Stall, PCSrc, BranchTarget, IMemData,
    output IMemAddr, PC, IFID_Instruction, IFID_PCPlus4, IFID_Valid
  );

  modport slave (
    output Stall, PCSrc, BranchTarget, IMemData,
    input  IMemAddr, PC, IFID_Instruction, IFID_PCPlus4, IFID_Valid
  );

endinterface

// File: rtl/fetch_stage_pc_register.sv
// Program counter flop: async reset, load (redirect) wins over enable (advance).
module fetch_stage_pc_register #(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic        i_load,
  input  logic [31:0] i_load_val,
  input  logic [31:0] i_next,
  output logic [31:0] o_q
);

  logic [31:0] r_q;

  // Redirect load has priority; otherwise advance only when enabled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       r_q <= RESET_VAL;
    else if (i_load) r_q <= i_load_val;
    else if (i_en)   r_q <= i_next;
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch stage with IF/ID pipeline register.
// Redirect (PCSrc) flushes IF/ID and overrides Stall; Stall freezes PC and IF/ID.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic          Clk,
  input  logic          Rst,
  fetch_stage_if.master bus
);

  logic [31:0] w_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic        w_unused_bits;
  ifid_t       r_ifid;

  // Target low bits are discarded; the sum wraps naturally at 2^32.
  assign w_target      = pc_align(bus.BranchTarget);
  assign w_pc_plus4    = w_pc + 32'd4;
  assign w_unused_bits = ^bus.BranchTarget[1:0];

  fetch_stage_pc_register #(
    .RESET_VAL (pc_align(RESET_PC))
  ) u_pc (
    .i_clk      (Clk),
    .i_rst      (Rst),
    .i_en       (~bus.Stall),
    .i_load     (bus.PCSrc),
    .i_load_val (w_target),
    .i_next     (w_pc_plus4),
    .o_q        (w_pc)
  );

  // IF/ID register: flush on redirect, hold on stall, else capture the fetched word.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_ifid <= '{instr: NOP_INSTR, pc_plus4: 32'd0, valid: 1'b0};
    end else if (bus.PCSrc) begin
      r_ifid <= '{instr: NOP_INSTR, pc_plus4: 32'd0, valid: 1'b0};
    end else if (!bus.Stall) begin
      r_ifid <= '{instr: bus.IMemData, pc_plus4: w_pc_plus4, valid: 1'b1};
    end
  end

  assign bus.IMemAddr         = w_pc;
  assign bus.PC               = w_pc;
  assign bus.IFID_Instruction = r_ifid.instr;
  assign bus.IFID_PCPlus4     = r_ifid.pc_plus4;
  assign bus.IFID_Valid       = r_ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a spec-level model predicts each edge's IF/ID
// contents, pushes them to a scoreboard queue, and pops/compares after the edge.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic Clk = 1'b0;
  logic Rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  fetch_stage_if bus ();

  fetch_stage dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  // Instruction memory: a distinct word per address, never equal to the NOP.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign bus.IMemData = mem_word(bus.IMemAddr);

  // Model state and scoreboard
  logic [31:0] m_pc;
  ifid_t       m_ifid;
  ifid_t       sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = 32'h0;
    m_ifid = '{instr: 32'h0, pc_plus4: 32'h0, valid: 1'b0};
  endtask

  // One clock: drive controls, predict, wait the edge, pop and compare.
  task automatic step(input string tag, input logic stall, input logic pcsrc,
                      input logic [31:0] tgt);
    ifid_t e;
    bus.Stall        = stall;
    bus.PCSrc        = pcsrc;
    bus.BranchTarget = tgt;
    if (pcsrc) begin
      m_ifid = '{instr: 32'h0, pc_plus4: 32'h0, valid: 1'b0};
      m_pc   = {tgt[31:2], 2'b00};
    end else if (!stall) begin
      m_ifid = '{instr: mem_word(m_pc), pc_plus4: m_pc + 32'd4, valid: 1'b1};
      m_pc   = m_pc + 32'd4;
    end
    sb_q.push_back(m_ifid);
    @(posedge Clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, ".pc"},    bus.PC,               m_pc);
    chk({tag, ".addr"},  bus.IMemAddr,         m_pc);
    chk({tag, ".instr"}, bus.IFID_Instruction, e.instr);
    chk({tag, ".pc4"},   bus.IFID_PCPlus4,     e.pc_plus4);
    chk({tag, ".valid"}, {31'd0, bus.IFID_Valid}, {31'd0, e.valid});
    @(negedge Clk);
  endtask

  initial begin
    Rst              = 1'b1;
    bus.Stall        = 1'b0;
    bus.PCSrc        = 1'b0;
    bus.BranchTarget = 32'h0;
    model_reset();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst.pc",    bus.PC,               32'h0);
    chk("rst.valid", {31'd0, bus.IFID_Valid}, 32'h0);
    Rst = 1'b0;

    // Run a few instructions, then reset mid-cycle
    step("pre0", 1'b0, 1'b0, 32'h0);
    step("pre1", 1'b0, 1'b0, 32'h0);
    step("pre2", 1'b0, 1'b0, 32'h0);
    #2 Rst = 1'b1;
    #1;
    chk("t1.pc",    bus.PC,               32'h0);
    chk("t1.instr", bus.IFID_Instruction, 32'h0);
    chk("t1.pc4",   bus.IFID_PCPlus4,     32'h0);
    chk("t1.valid", {31'd0, bus.IFID_Valid}, 32'h0);
    @(negedge Clk);
    Rst = 1'b0;
    model_reset();
    chk("t1.pc_rel", bus.PC, 32'h0);

    // T2 stream / T3 stall: W0, W1, then three stalled cycles, then W2
    step("t2.w0", 1'b0, 1'b0, 32'h0);
    step("t2.w1", 1'b0, 1'b0, 32'h0);
    step("t3.s0", 1'b1, 1'b0, 32'h0);
    step("t3.s1", 1'b1, 1'b0, 32'h0);
    step("t3.s2", 1'b1, 1'b0, 32'h0);
    chk("t3.hold_instr", bus.IFID_Instruction, mem_word(32'h4));
    chk("t3.hold_pc",    bus.PC,               32'h8);
    step("t3.w2", 1'b0, 1'b0, 32'h0);
    chk("t3.w2_instr", bus.IFID_Instruction, mem_word(32'h8));
    step("t2.w3", 1'b0, 1'b0, 32'h0);

    // T4 redirect: bubble then target
    step("t4.redir", 1'b0, 1'b1, 32'h40);
    step("t4.tgt",   1'b0, 1'b0, 32'h0);
    chk("t4.tgt_pc4", bus.IFID_PCPlus4, 32'h44);

    // T5 redirect overrides stall, low bits cleared
    step("t5.both", 1'b1, 1'b1, 32'h103);
    chk("t5.pc", bus.PC, 32'h100);
    step("t5.next", 1'b0, 1'b0, 32'h0);

    // Redirect to the current PC: re-fetch after one bubble
    step("self.redir", 1'b0, 1'b1, 32'h104);
    step("self.tgt",   1'b0, 1'b0, 32'h0);

    // T6 wrap at the top of the address space
    step("t6.redir", 1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("t6.pc_top", bus.PC, 32'hFFFF_FFFC);
    step("t6.wrap",  1'b0, 1'b0, 32'h0);
    chk("t6.pc0",  bus.PC,           32'h0);
    chk("t6.pc4",  bus.IFID_PCPlus4, 32'h0);
    step("t6.after", 1'b0, 1'b0, 32'h0);

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard: %0d entries left, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog: the directed sequence is a few hundred ns.
  initial begin
    #20000;
    $display("FAIL watchdog: time %0t, want finish before 20000", $time);
    $fatal(1, "timeout");
  end

endmodule
